// File: rtl/eth_tx_pkg.sv
// Shared constants and types for the Ethernet TX FCS path.
// Optional short-frame padding is enabled with the ETH_TX_MIN_PAD_EN macro.
package eth_tx_pkg;

    localparam int          ETH_MIN_FRAME_NOFCS = 60;
    localparam int          ETH_FCS_LEN         = 4;
    localparam logic [31:0] ETH_CRC32_POLY      = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC32_INIT      = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAD  = 2'd1,
        FCS  = 2'd2
    } tx_fcs_state_e;

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational reflected CRC32 update for one byte, bit 0 of the byte first.
// Shared by the TX FCS appender and the RX FCS checker.
module eth_crc32_byte
    import eth_tx_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_c;

    // Eight unrolled shift/xor steps of the LSB-first CRC register
    always_comb begin
        w_c = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_c[0] ^ i_data[i]) begin
                w_c = (w_c >> 1) ^ ETH_CRC32_POLY;
            end else begin
                w_c = w_c >> 1;
            end
        end
    end

    assign o_crc = w_c;

endmodule

// File: rtl/eth_tx_fcs_appender.sv
// Passes byte frames through unchanged, optionally zero-pads short frames to
// MIN_FRAME_LEN, then appends the 4-byte CRC32 FCS (LSB byte first).
// Padding is compiled in only when ETH_TX_MIN_PAD_EN is defined.
module eth_tx_fcs_appender
    import eth_tx_pkg::*;
#(
    parameter int MIN_FRAME_LEN = ETH_MIN_FRAME_NOFCS,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    output logic       frame_done,
    output logic       busy
);

    localparam logic [1:0] FCS_LAST = 2'(ETH_FCS_LEN - 1);

    tx_fcs_state_e    r_state;
    tx_fcs_state_e    w_state_next;
    logic [31:0]      r_crc;
    logic [31:0]      w_crc_upd;
    logic [31:0]      w_fcs;
    logic [CNT_W-1:0] r_byte_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [1:0]       r_fcs_idx;
    logic             r_frame_done;
    logic             r_busy;
    logic [7:0]       w_crc_byte;
    logic             w_xfer;

    eth_crc32_byte u_crc (
        .i_crc  (r_crc),
        .i_data (w_crc_byte),
        .o_crc  (w_crc_upd)
    );

    // Counter saturates so very long frames never wrap back into "short"
    assign w_cnt_inc = (&r_byte_cnt) ? r_byte_cnt : r_byte_cnt + CNT_W'(1);
    assign w_fcs     = ~r_crc;

`ifdef ETH_TX_MIN_PAD_EN
    logic w_short;
    logic w_pad_done;
    assign w_short    = ({1'b0, r_byte_cnt} + (CNT_W+1)'(1)) < (CNT_W+1)'(MIN_FRAME_LEN);
    assign w_pad_done = (w_cnt_inc == CNT_W'(MIN_FRAME_LEN));
`endif

    // Next-state and output decode; everything is quiet while reset is held
    always_comb begin
        w_state_next  = r_state;
        s_axis_tready = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = 8'h00;
        m_axis_tlast  = 1'b0;
        w_crc_byte    = 8'h00;
        w_xfer        = 1'b0;
        if (!rst) begin
            case (r_state)
                DATA: begin
                    m_axis_tdata  = s_axis_tdata;
                    m_axis_tvalid = s_axis_tvalid;
                    s_axis_tready = m_axis_tready;
                    w_crc_byte    = s_axis_tdata;
                    w_xfer        = s_axis_tvalid && m_axis_tready;
                    if (w_xfer && s_axis_tlast) begin
`ifdef ETH_TX_MIN_PAD_EN
                        w_state_next = w_short ? PAD : FCS;
`else
                        w_state_next = FCS;
`endif
                    end
                end
`ifdef ETH_TX_MIN_PAD_EN
                PAD: begin
                    m_axis_tvalid = 1'b1;
                    w_xfer        = m_axis_tready;
                    if (w_xfer && w_pad_done) begin
                        w_state_next = FCS;
                    end
                end
`endif
                FCS: begin
                    m_axis_tvalid = 1'b1;
                    m_axis_tdata  = w_fcs[{r_fcs_idx, 3'b000} +: 8];
                    m_axis_tlast  = (r_fcs_idx == FCS_LAST);
                    w_xfer        = m_axis_tready;
                    if (w_xfer && (r_fcs_idx == FCS_LAST)) begin
                        w_state_next = DATA;
                    end
                end
                default: begin
                    w_state_next = DATA;
                end
            endcase
        end
    end

    // State, CRC accumulator, byte counter and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= DATA;
            r_crc        <= ETH_CRC32_INIT;
            r_byte_cnt   <= '0;
            r_fcs_idx    <= 2'd0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_frame_done <= 1'b0;
            if (w_xfer) begin
                if (r_state == FCS) begin
                    if (r_fcs_idx == FCS_LAST) begin
                        r_crc        <= ETH_CRC32_INIT;
                        r_byte_cnt   <= '0;
                        r_fcs_idx    <= 2'd0;
                        r_frame_done <= 1'b1;
                        r_busy       <= 1'b0;
                    end else begin
                        r_fcs_idx <= r_fcs_idx + 2'd1;
                    end
                end else begin
                    r_crc      <= w_crc_upd;
                    r_byte_cnt <= w_cnt_inc;
                    r_busy     <= 1'b1;
                end
            end
        end
    end

    assign frame_done = r_frame_done;
    assign busy       = r_busy;

endmodule

// File: tb/tb_eth_tx_fcs_appender.sv
// Scoreboard bench for eth_tx_fcs_appender: stimulus pushes the expected
// output byte stream, a monitor pops and compares on every output transfer.
module tb_eth_tx_fcs_appender;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;
    logic       s_axis_tlast;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic       m_axis_tlast;
    logic       frame_done;
    logic       busy;

    always #5 clk = ~clk;

    eth_tx_fcs_appender #(
        .MIN_FRAME_LEN (60),
        .CNT_W         (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .frame_done    (frame_done),
        .busy          (busy)
    );

    typedef struct {
        logic [7:0] data;
        logic       last;
        logic       held;   // generated byte: tvalid must stay high
        logic       gap;    // must transfer the cycle after the previous tlast
    } exp_t;

    exp_t       sb[$];
    logic [7:0] frm[$];
    logic [7:0] buf_q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         last_tlast_cyc = -100;
    bit         exp_done = 1'b0;
    bit         rand_rdy = 1'b0;
    int         frame_no = 0;

    function automatic logic [31:0] crc_model();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (buf_q[i]) begin
            c = c ^ {24'h0, buf_q[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic l, input logic h, input logic g);
        exp_t e;
        e.data = d; e.last = l; e.held = h; e.gap = g;
        sb.push_back(e);
    endtask

    // PHY-side ready: always 1, or ~50% random when enabled
    initial begin
        m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares every output transfer against the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                checks++;
                if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_quiet: tvalid=%0b tlast=%0b required 0 0", m_axis_tvalid, m_axis_tlast);
                end
                exp_done = 1'b0;
            end else begin
                if (frame_done || exp_done) begin
                    checks++;
                    if (frame_done !== exp_done) begin
                        errors++;
                        $display("FAIL frame_done: got %0b required %0b (cycle %0d)", frame_done, exp_done, cyc);
                    end
                end
                exp_done = 1'b0;
                if (sb.size() > 0 && sb[0].held) begin
                    checks++;
                    if (m_axis_tvalid !== 1'b1) begin
                        errors++;
                        $display("FAIL tvalid_hold: got %0b required 1 (cycle %0d)", m_axis_tvalid, cyc);
                    end
                end
                if (m_axis_tvalid && m_axis_tready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %02h with nothing expected", m_axis_tdata);
                    end else begin
                        e = sb.pop_front();
                        checks++;
                        if (m_axis_tdata !== e.data || m_axis_tlast !== e.last) begin
                            errors++;
                            $display("FAIL out_byte: got %02h last=%0b required %02h last=%0b (cycle %0d)",
                                     m_axis_tdata, m_axis_tlast, e.data, e.last, cyc);
                        end
                        if (e.gap) begin
                            checks++;
                            if (cyc != last_tlast_cyc + 1) begin
                                errors++;
                                $display("FAIL b2b_gap: first byte at cycle %0d required %0d", cyc, last_tlast_cyc + 1);
                            end
                        end
                        if (e.last) begin
                            last_tlast_cyc = cyc;
                            exp_done = 1'b1;
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l);
        bit hs;
        bit done;
        done = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge clk);
            #1;
            if (hs) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL in_handshake: byte %02h never accepted", d);
        end
    endtask

    // Pushes the expected stream for frm[], then drives it
    task automatic run_frame(input bit hand, input logic [31:0] hand_fcs, input bit keep_valid, input bit gap_first);
        logic [31:0] fcs;
        buf_q = {};
        foreach (frm[i]) begin
            push_exp(frm[i], 1'b0, 1'b0, gap_first && (i == 0));
            buf_q.push_back(frm[i]);
        end
`ifdef ETH_TX_MIN_PAD_EN
        while (buf_q.size() < 60) begin
            buf_q.push_back(8'h00);
            push_exp(8'h00, 1'b0, 1'b1, 1'b0);
        end
`endif
        fcs = hand ? hand_fcs : crc_model();
        for (int k = 0; k < 4; k++) begin
            push_exp(fcs[8*k +: 8], (k == 3), 1'b1, 1'b0);
        end
        frame_no++;
        $display("frame %0d: %0d input bytes, %0d output bytes expected, fcs %08h",
                 frame_no, frm.size(), buf_q.size() + 4, fcs);
        foreach (frm[i]) begin
            send_byte(frm[i], (i == frm.size() - 1));
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_set: got %0b required 1", busy);
                end
            end
        end
        if (!keep_valid) begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 3000; t++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected bytes never appeared", sb.size());
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_clear: got %0b required 0", busy);
        end
    endtask

    task automatic load_check_string();
        logic [7:0] s;
        frm = {};
        for (int i = 0; i < 9; i++) begin
            s = 8'h31 + 8'(i);
            frm.push_back(s);
        end
    endtask

    task automatic run_check_string();
        load_check_string();
`ifdef ETH_TX_MIN_PAD_EN
        run_frame(1'b0, 32'h0, 1'b0, 1'b0);
`else
        run_frame(1'b1, 32'hCBF43926, 1'b0, 1'b0);
`endif
        wait_drain();
    endtask

    initial begin
        rst           = 1'b1;
        s_axis_tdata  = 8'h00;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;

        // Reset state
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_axis_tready !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: tready=%0b busy=%0b done=%0b required 0 0 0",
                         s_axis_tready, busy, frame_done);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // "123456789" check string
        run_check_string();

        // 64 bytes of A5: no padding either way
        frm = {};
        for (int i = 0; i < 64; i++) frm.push_back(8'hA5);
        run_frame(1'b0, 32'h0, 1'b0, 1'b0);
        wait_drain();

        // 60-byte frame under random backpressure
        rand_rdy = 1'b1;
        frm = {};
        for (int i = 0; i < 60; i++) frm.push_back(8'(i * 7 + 1));
        run_frame(1'b0, 32'h0, 1'b0, 1'b0);
        wait_drain();
        rand_rdy = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Two back-to-back frames, input valid never dropped
        frm = {};
        for (int i = 0; i < 10; i++) frm.push_back(8'(i * 3));
        run_frame(1'b0, 32'h0, 1'b1, 1'b0);
        frm = {};
        for (int i = 0; i < 12; i++) frm.push_back(8'(8'hF0 - i));
        run_frame(1'b0, 32'h0, 1'b0, 1'b1);
        wait_drain();

        // Reset while byte 20 of a 30-byte frame is presented
        $display("frame %0d: reset mid-frame after 19 bytes", frame_no + 1);
        frame_no++;
        for (int i = 0; i < 19; i++) begin
            push_exp(8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
            send_byte(8'(8'h40 + i), 1'b0);
        end
        s_axis_tdata  = 8'h53;
        s_axis_tvalid = 1'b1;
        rst           = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL rst_tready: got %0b required 0", s_axis_tready);
            end
        end
        @(posedge clk);
        #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL rst_partial: %0d bytes of partial frame not seen", sb.size());
            sb = {};
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %0b required 0", busy);
        end
        repeat (2) @(posedge clk);
        #1;

        // Clean frame after the aborted one
        run_check_string();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/eth_tx_fcs_appender.md
Name: eth_tx_fcs_appender

Overview:
Sits directly downstream of the TCP sender's PHY output (phy_axis) and upstream of the MAC/PHY byte interface. Takes byte-wide Ethernet frames without FCS and passes each byte through unchanged. After the last input byte it pads short frames to the 60-byte Ethernet minimum (when padding is compiled in), then appends the 4-byte IEEE 802.3 CRC32 FCS. Output tlast moves from the last payload byte to the last FCS byte.

Parameters:
MIN_FRAME_LEN, 60, minimum frame length in bytes excluding FCS; padding target.
CNT_W, 16, width of the per-frame byte counter; the counter saturates.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
s_axis_tdata  in  8  frame byte from the tcp_sender output.
s_axis_tvalid  in  1  input byte valid.
s_axis_tready  out  1  input byte accepted.
s_axis_tlast  in  1  last byte of the frame, FCS excluded.
m_axis_tdata  out  8  byte to the PHY.
m_axis_tvalid  out  1  output byte valid.
m_axis_tready  in  1  PHY backpressure.
m_axis_tlast  out  1  asserted on the 4th FCS byte only.
frame_done  out  1  one-cycle pulse when the final FCS byte is accepted.
busy  out  1  high from the first accepted byte until frame_done.

Behaviour:
- States: DATA, PAD, FCS. Reset puts the block in DATA with crc=32'hFFFFFFFF, byte_cnt=0, fcs_idx=0, frame_done=0, busy=0.
- While rst=1: s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0.
- DATA is a combinational pass-through with zero latency:
  - m_axis_tdata=s_axis_tdata, m_axis_tvalid=s_axis_tvalid, s_axis_tready=m_axis_tready, m_axis_tlast=0.
  - A transfer is s_axis_tvalid && m_axis_tready. On each transfer: crc updated with the byte, byte_cnt increments and saturates at 2^CNT_W-1, busy=1.
  - On a transfer with s_axis_tlast=1: go to PAD if padding is enabled and byte_cnt+1 < MIN_FRAME_LEN; otherwise go to FCS.
- PAD:
  - s_axis_tready=0, m_axis_tvalid=1, m_axis_tdata=8'h00, m_axis_tlast=0.
  - Each accepted byte updates crc and byte_cnt.
  - Go to FCS on the transfer that makes byte_cnt == MIN_FRAME_LEN.
- FCS:
  - s_axis_tready=0, m_axis_tvalid=1.
  - m_axis_tdata = ~crc, byte fcs_idx: idx0 = bits [7:0], then [15:8], [23:16], [31:24]. LSB byte is sent first.
  - m_axis_tlast = (fcs_idx==3).
  - On the idx3 transfer: frame_done=1 for one cycle, busy=0, crc and byte_cnt reload their reset values, fcs_idx=0, return to DATA.
  - The next frame may begin on the following cycle. There is no inter-frame gap here; IFG belongs to the MAC.
- CRC: reflected polynomial 32'hEDB88320, init 32'hFFFFFFFF, byte processed LSB-first, final XOR all ones. Covers every byte sent, padding included.
- Backpressure: m_axis_tready=0 holds state, crc, data and tlast stable. In PAD/FCS, m_axis_tvalid stays high until accepted; it never drops mid-frame.
- Input with tvalid=0 mid-frame in DATA: the output bubbles and the frame is not aborted.
- Frames of 1 byte are legal; they pad to 60 bytes.
- Frames longer than 2^CNT_W-1 bytes: byte_cnt saturates and FCS remains correct.
- Reset mid-frame: the partial frame is dropped with no FCS. The PHY sees tvalid fall with no tlast. State returns to DATA on the cycle after rst deasserts.

Optional Feature:
ETH_TX_MIN_PAD_EN
- Defined: short frames are zero-padded to MIN_FRAME_LEN before the FCS, and the PAD state exists.
- Undefined: the PAD state and its comparison logic are removed; DATA with tlast always goes to FCS, so a 9-byte frame produces 13 output bytes.
- byte_cnt is kept either way, for busy and debug.

Decomposition:
- Package eth_tx_pkg:
  - ETH_MIN_FRAME_NOFCS=60, ETH_FCS_LEN=4, ETH_CRC32_POLY=32'hEDB88320, ETH_CRC32_INIT=32'hFFFFFFFF.
  - Enum tx_fcs_state_e {DATA, PAD, FCS}.
- Sub-module eth_crc32_byte: combinational next-CRC from (crc_in[31:0], data[7:0]), unrolled over 8 bits. It is reused by the RX FCS checker.

Test Plan:
- Macro off, ASCII "123456789" (9 bytes, tlast on '9'), m_axis_tready=1 -> output is the 9 bytes then 26 39 F4 CB; tlast on CB; frame_done pulses once; 13 output bytes total.
- Macro on, same 9 bytes -> 9 data bytes, 51 bytes of 00, then the 4 FCS bytes matching a software CRC32 of the 60-byte buffer; 64 output bytes total; tlast only on byte 64.
- Macro on, 64-byte frame of 8'hA5 -> no padding; 68 output bytes; FCS matches the model.
- Random m_axis_tready toggling (~50%) on a 60-byte frame -> byte stream and FCS identical to the tready=1 run; m_axis_tvalid never deasserts in PAD/FCS until the transfer.
- Two back-to-back frames with s_axis_tvalid held high -> the second frame's first byte appears the cycle after the first frame's tlast transfer; each FCS is independent, showing crc reinit.
- rst pulsed during byte 20 of a frame -> m_axis_tvalid=0 while rst=1; the following 9-byte frame produces a correct FCS, with no leftover crc, byte count or padding state.
